// File: rtl/pim_seq_pkg.sv
// Shared types and constants for the PIM row sequencer: FSM states, array
// command codes, row-select codes, memory opcodes and per-opcode step counts.
package pim_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_POP,
      ST_LOAD,
      ST_ISSUE,
      ST_RETIRE
   } state_t;

   typedef enum logic [1:0] {
      CMD_ACT_A = 2'd0,
      CMD_ACT_B = 2'd1,
      CMD_EVAL  = 2'd2,
      CMD_INIT  = 2'd3
   } arr_cmd_t;

   // Which captured address feeds arr_row for a given step.
   typedef enum logic [1:0] {
      SEL_DEST = 2'd0,
      SEL_SRC1 = 2'd1,
      SEL_SRC2 = 2'd2
   } row_sel_t;

   localparam logic [1:0] OP_NOP   = 2'd0;
   localparam logic [1:0] OP_LOGIC = 2'd1;
   localparam logic [1:0] OP_INIT  = 2'd2;
   localparam logic [1:0] OP_COPY  = 2'd3;

   localparam logic [1:0] STEPS_NOP   = 2'd0;
   localparam logic [1:0] STEPS_LOGIC = 2'd3;
   localparam logic [1:0] STEPS_INIT  = 2'd1;
   localparam logic [1:0] STEPS_COPY  = 2'd2;

   // Number of array commands an opcode expands into.
   function automatic logic [1:0] op_steps(input logic [1:0] op);
      case (op)
         OP_LOGIC: op_steps = STEPS_LOGIC;
         OP_INIT:  op_steps = STEPS_INIT;
         OP_COPY:  op_steps = STEPS_COPY;
         default:  op_steps = STEPS_NOP;
      endcase
   endfunction

endpackage

// File: rtl/pim_cmd_rom.sv
// Combinational expansion table: (opcode, step) -> array command, which
// captured row feeds it, and whether this is the final step of the opcode.
module pim_cmd_rom
   import pim_seq_pkg::*;
(
   input  logic [1:0] op,
   input  logic [1:0] step,
   output logic [1:0] cmd,
   output logic [1:0] row_sel,
   output logic       last
);

   // Table lookup; NOP never reaches ISSUE so its entry is don't-care.
   always_comb begin
      cmd     = CMD_ACT_A;
      row_sel = SEL_DEST;
      last    = ((step + 2'd1) == op_steps(op));
      case (op)
         OP_LOGIC: begin
            case (step)
               2'd0: begin cmd = CMD_ACT_A; row_sel = SEL_SRC1; end
               2'd1: begin cmd = CMD_ACT_B; row_sel = SEL_SRC2; end
               default: begin cmd = CMD_EVAL; row_sel = SEL_DEST; end
            endcase
         end
         OP_INIT: begin
            cmd     = CMD_INIT;
            row_sel = SEL_DEST;
         end
         OP_COPY: begin
            if (step == 2'd0) begin
               cmd     = CMD_ACT_A;
               row_sel = SEL_SRC1;
            end else begin
               cmd     = CMD_EVAL;
               row_sel = SEL_DEST;
            end
         end
         default: begin
            cmd     = CMD_ACT_A;
            row_sel = SEL_DEST;
         end
      endcase
   end

endmodule

// File: rtl/pim_row_sequencer.sv
// PIM row sequencer: pops decoded entries from the address/op FIFOs and
// expands each into single-row commands on the crossbar-array port.
// Optional statistics counters are built when PIM_SEQ_STATS_EN is defined.
module pim_row_sequencer
   import pim_seq_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fifo_empty,
   input  logic [ADDR_W-1:0] dest_addr,
   input  logic [ADDR_W-1:0] src1_addr,
   input  logic [ADDR_W-1:0] src2_addr,
   input  logic [1:0]        mem_op,
   output logic              read,
   output logic              arr_valid,
   input  logic              arr_ready,
   output logic [1:0]        arr_cmd,
   output logic [ADDR_W-1:0] arr_row,
   output logic              busy,
   output logic              op_done
`ifdef PIM_SEQ_STATS_EN
   ,
   output logic [CNT_W-1:0]  ops_retired,
   output logic [CNT_W-1:0]  stall_cycles
`endif
);

   state_t            state_reg, state_next;
   logic              read_reg, read_next;
   logic [ADDR_W-1:0] dest_reg, src1_reg, src2_reg;
   logic [1:0]        op_reg;
   logic [1:0]        step_reg;
   logic [1:0]        rom_cmd;
   logic [1:0]        rom_sel;
   logic              rom_last;
   logic [ADDR_W-1:0] row_mux;
   logic              handshake;

   pim_cmd_rom u_rom (
      .op      (op_reg),
      .step    (step_reg),
      .cmd     (rom_cmd),
      .row_sel (rom_sel),
      .last    (rom_last)
   );

   assign handshake = (state_reg == ST_ISSUE) && arr_ready;

   // State and the registered pop strobe (read lands in the POP cycle).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         read_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         read_reg  <= read_next;
      end
   end

   // Capture the FIFO entry in LOAD and advance the step on each accepted command.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         dest_reg <= '0;
         src1_reg <= '0;
         src2_reg <= '0;
         op_reg   <= OP_NOP;
         step_reg <= 2'd0;
      end else if (state_reg == ST_LOAD) begin
         dest_reg <= dest_addr;
         src1_reg <= src1_addr;
         src2_reg <= src2_addr;
         op_reg   <= mem_op;
         step_reg <= 2'd0;
      end else if (handshake) begin
         step_reg <= step_reg + 2'd1;
      end
   end

   // Next-state logic; fifo_empty only matters in IDLE and RETIRE.
   always_comb begin
      state_next = state_reg;
      read_next  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               read_next  = 1'b1;
               state_next = ST_POP;
            end
         end
         ST_POP:   state_next = ST_LOAD;
         ST_LOAD:  state_next = (mem_op == OP_NOP) ? ST_RETIRE : ST_ISSUE;
         ST_ISSUE: begin
            if (arr_ready && rom_last) state_next = ST_RETIRE;
         end
         ST_RETIRE: begin
            if (!fifo_empty) begin
               read_next  = 1'b1;
               state_next = ST_POP;
            end else begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Select the captured row named by the ROM for the current step.
   always_comb begin
      row_mux = dest_reg;
      case (rom_sel)
         SEL_SRC1: row_mux = src1_reg;
         SEL_SRC2: row_mux = src2_reg;
         default:  row_mux = dest_reg;
      endcase
   end

   // Command outputs derive from the state register so reset clears them at once.
   assign read      = read_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign op_done   = (state_reg == ST_RETIRE);
   assign arr_valid = (state_reg == ST_ISSUE);
   assign arr_cmd   = arr_valid ? rom_cmd : 2'd0;
   assign arr_row   = arr_valid ? row_mux : '0;

`ifdef PIM_SEQ_STATS_EN
   logic [CNT_W-1:0] ops_reg, stall_reg;

   // Saturating retired-entry and array-stall counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ops_reg   <= '0;
         stall_reg <= '0;
      end else begin
         if ((state_reg == ST_RETIRE) && (op_reg != OP_NOP) && (ops_reg != '1))
            ops_reg <= ops_reg + CNT_W'(1);
         if ((state_reg == ST_ISSUE) && !arr_ready && (stall_reg != '1))
            stall_reg <= stall_reg + CNT_W'(1);
      end
   end

   assign ops_retired  = ops_reg;
   assign stall_cycles = stall_reg;
`else
   logic unused_cnt_w;
   assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_pim_row_sequencer.sv
// Self-checking bench for pim_row_sequencer. A queue-based FIFO model feeds
// the DUT; expected array command streams come from expanding each pushed
// entry by the opcode table. Counter checks are built with PIM_SEQ_STATS_EN.
module tb_pim_row_sequencer;

   localparam int ADDR_W = 10;
   localparam int CNT_W  = 16;

   typedef struct {
      logic [9:0] dest;
      logic [9:0] src1;
      logic [9:0] src2;
      logic [1:0] op;
   } entry_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              fifo_empty = 1'b1;
   logic [ADDR_W-1:0] dest_addr = '0;
   logic [ADDR_W-1:0] src1_addr = '0;
   logic [ADDR_W-1:0] src2_addr = '0;
   logic [1:0]        mem_op = 2'd0;
   logic              read;
   logic              arr_valid;
   logic              arr_ready = 1'b1;
   logic [1:0]        arr_cmd;
   logic [ADDR_W-1:0] arr_row;
   logic              busy;
   logic              op_done;
`ifdef PIM_SEQ_STATS_EN
   logic [CNT_W-1:0]  ops_retired;
   logic [CNT_W-1:0]  stall_cycles;
`endif

   pim_row_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .fifo_empty   (fifo_empty),
      .dest_addr    (dest_addr),
      .src1_addr    (src1_addr),
      .src2_addr    (src2_addr),
      .mem_op       (mem_op),
      .read         (read),
      .arr_valid    (arr_valid),
      .arr_ready    (arr_ready),
      .arr_cmd      (arr_cmd),
      .arr_row      (arr_row),
      .busy         (busy),
      .op_done      (op_done)
`ifdef PIM_SEQ_STATS_EN
      ,
      .ops_retired  (ops_retired),
      .stall_cycles (stall_cycles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   entry_t fifo_q[$];
   int exp_cmd[$], exp_row[$];
   int hs_cmd[$], hs_row[$], hs_cyc[$];
   int read_cyc[$], done_cyc[$], valid_cyc[$];
   int stab_err, rd_empty_err, stall_obs, nonnop_cnt;
   int stall_left = 0;
   int rand_ready = 0;
   int cyc = 0;
   logic       prev_stall = 1'b0;
   logic [1:0] prev_cmd = 2'd0;
   logic [9:0] prev_row = '0;

   // Expected command list of one entry, straight from the opcode table.
   task automatic push(input entry_t e);
      fifo_q.push_back(e);
      case (e.op)
         2'd1: begin
            exp_cmd.push_back(0); exp_row.push_back(int'(e.src1));
            exp_cmd.push_back(1); exp_row.push_back(int'(e.src2));
            exp_cmd.push_back(2); exp_row.push_back(int'(e.dest));
         end
         2'd2: begin
            exp_cmd.push_back(3); exp_row.push_back(int'(e.dest));
         end
         2'd3: begin
            exp_cmd.push_back(0); exp_row.push_back(int'(e.src1));
            exp_cmd.push_back(2); exp_row.push_back(int'(e.dest));
         end
         default: ;
      endcase
      if (e.op != 2'd0) nonnop_cnt++;
      fifo_empty = 1'b0;
   endtask

   function automatic entry_t mk(input int op, input int d, input int s1, input int s2);
      entry_t e;
      e.op = 2'(op); e.dest = 10'(d); e.src1 = 10'(s1); e.src2 = 10'(s2);
      return e;
   endfunction

   task automatic clear_logs();
      exp_cmd.delete(); exp_row.delete();
      hs_cmd.delete(); hs_row.delete(); hs_cyc.delete();
      read_cyc.delete(); done_cyc.delete(); valid_cyc.delete();
      stab_err = 0; rd_empty_err = 0; stall_obs = 0; nonnop_cnt = 0;
      prev_stall = 1'b0;
   endtask

   // One clock: drive ready and observe at negedge, move FIFO data after posedge.
   task automatic run_cycle();
      logic rd;
      entry_t e;
      @(negedge clk);
      cyc++;
      if (stall_left > 0 && arr_valid) begin
         arr_ready = 1'b0;
         stall_left--;
      end else if (rand_ready != 0) begin
         arr_ready = ($urandom_range(0, 3) != 0);
      end else begin
         arr_ready = 1'b1;
      end
      if (prev_stall && (!arr_valid || arr_cmd !== prev_cmd || arr_row !== prev_row))
         stab_err++;
      if (arr_valid) valid_cyc.push_back(cyc);
      if (arr_valid && !arr_ready) stall_obs++;
      if (arr_valid && arr_ready) begin
         hs_cmd.push_back(int'(arr_cmd));
         hs_row.push_back(int'(arr_row));
         hs_cyc.push_back(cyc);
      end
      if (op_done) done_cyc.push_back(cyc);
      if (read) begin
         read_cyc.push_back(cyc);
         if (fifo_empty) rd_empty_err++;
      end
      prev_stall = arr_valid && !arr_ready;
      prev_cmd   = arr_cmd;
      prev_row   = arr_row;
      rd = read;
      @(posedge clk);
      #1;
      if (rd && fifo_q.size() > 0) begin
         e = fifo_q.pop_front();
         dest_addr = e.dest;
         src1_addr = e.src1;
         src2_addr = e.src2;
         mem_op    = e.op;
      end
      fifo_empty = (fifo_q.size() == 0);
   endtask

   // Number of accepted commands that differ from the expected stream.
   function automatic int stream_errors();
      int errs = 0;
      if (hs_cmd.size() != exp_cmd.size()) return 1000;
      foreach (exp_cmd[i])
         if (hs_cmd[i] != exp_cmd[i] || hs_row[i] != exp_row[i]) errs++;
      return errs;
   endfunction

   task automatic wait_done(input int n, input int budget, input string name);
      int k = 0;
      while (done_cyc.size() < n && k < budget) begin
         run_cycle();
         k++;
      end
      n_checks++;
      if (done_cyc.size() < n) begin
         n_fail++;
         $display("FAIL %s_timeout: op_done count %0d required %0d", name, done_cyc.size(), n);
      end
      repeat (3) run_cycle();
   endtask

   task automatic test_reset();
      #2;
      n_checks++; if (read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %0b required 0", read); end
      n_checks++; if (arr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", arr_valid); end
      n_checks++; if (arr_cmd !== 2'd0) begin n_fail++; $display("FAIL reset_cmd: got %0d required 0", arr_cmd); end
      n_checks++; if (arr_row !== 10'd0) begin n_fail++; $display("FAIL reset_row: got %0d required 0", arr_row); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b required 0", busy); end
      n_checks++; if (op_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b required 0", op_done); end
`ifdef PIM_SEQ_STATS_EN
      n_checks++; if (ops_retired !== '0 || stall_cycles !== '0) begin n_fail++; $display("FAIL reset_counters: got %0d/%0d required 0/0", ops_retired, stall_cycles); end
`endif
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      $display("test_reset: done");
   endtask

   task automatic test_logic_single();
      clear_logs();
      push(mk(1, 12, 5, 9));
      wait_done(1, 40, "logic_single");
      n_checks++; if (stream_errors() != 0) begin n_fail++; $display("FAIL logic_stream: %0d bad of %0d got, required 0 bad of %0d", stream_errors(), hs_cmd.size(), exp_cmd.size()); end
      n_checks++; if (read_cyc.size() != 1) begin n_fail++; $display("FAIL logic_reads: got %0d required 1", read_cyc.size()); end
      if (read_cyc.size() >= 1 && hs_cyc.size() == 3 && done_cyc.size() >= 1) begin
         for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (hs_cyc[i] - read_cyc[0] != i + 2) begin n_fail++; $display("FAIL logic_cmd%0d_lat: got %0d required %0d", i, hs_cyc[i] - read_cyc[0], i + 2); end
         end
         n_checks++; if (done_cyc[0] - read_cyc[0] != 5) begin n_fail++; $display("FAIL logic_done_lat: got %0d required 5", done_cyc[0] - read_cyc[0]); end
      end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL logic_idle_busy: got %0b required 0", busy); end
      $display("test_logic_single: %0d commands", hs_cmd.size());
   endtask

   task automatic test_init_stall();
      int s0;
`ifdef PIM_SEQ_STATS_EN
      s0 = int'(stall_cycles);
`else
      s0 = 0;
`endif
      clear_logs();
      stall_left = 3;
      push(mk(2, 1023, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023))));
      wait_done(1, 40, "init_stall");
      n_checks++; if (stream_errors() != 0) begin n_fail++; $display("FAIL init_stream: %0d bad, required 0", stream_errors()); end
      n_checks++; if (valid_cyc.size() != 4) begin n_fail++; $display("FAIL init_valid_cycles: got %0d required 4", valid_cyc.size()); end
      n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL init_hold_stable: got %0d changes required 0", stab_err); end
`ifdef PIM_SEQ_STATS_EN
      n_checks++; if (int'(stall_cycles) - s0 != 3) begin n_fail++; $display("FAIL init_stall_count: got %0d required 3", int'(stall_cycles) - s0); end
`else
      if (s0 != 0) $display("test_init_stall: unexpected start");
`endif
      $display("test_init_stall: %0d valid cycles", valid_cyc.size());
   endtask

   task automatic test_nop_copy();
      int r0;
`ifdef PIM_SEQ_STATS_EN
      r0 = int'(ops_retired);
`else
      r0 = 0;
`endif
      clear_logs();
      push(mk(0, 33, 44, 55));
      push(mk(3, 7, 0, 99));
      wait_done(2, 60, "nop_copy");
      n_checks++; if (stream_errors() != 0) begin n_fail++; $display("FAIL nopcopy_stream: %0d bad, required 0", stream_errors()); end
      n_checks++; if (valid_cyc.size() != 2) begin n_fail++; $display("FAIL nopcopy_valid_cycles: got %0d required 2", valid_cyc.size()); end
      if (read_cyc.size() == 2 && valid_cyc.size() >= 1) begin
         n_checks++; if (valid_cyc[0] < read_cyc[1]) begin n_fail++; $display("FAIL nop_issued: valid at %0d before second read %0d", valid_cyc[0], read_cyc[1]); end
      end
`ifdef PIM_SEQ_STATS_EN
      n_checks++; if (int'(ops_retired) - r0 != 1) begin n_fail++; $display("FAIL nopcopy_retired: got %0d required 1", int'(ops_retired) - r0); end
`else
      if (r0 != 0) $display("test_nop_copy: unexpected start");
`endif
      $display("test_nop_copy: %0d commands", hs_cmd.size());
   endtask

   task automatic test_back_to_back();
      clear_logs();
      for (int i = 0; i < 4; i++)
         push(mk(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023))));
      wait_done(4, 80, "b2b");
      n_checks++; if (stream_errors() != 0) begin n_fail++; $display("FAIL b2b_stream: %0d bad, required 0", stream_errors()); end
      n_checks++; if (read_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_reads: got %0d required 4", read_cyc.size()); end
      n_checks++; if (done_cyc.size() != 4) begin n_fail++; $display("FAIL b2b_done: got %0d required 4", done_cyc.size()); end
      for (int i = 1; i < read_cyc.size(); i++) begin
         n_checks++;
         if (read_cyc[i] - read_cyc[i-1] != 6) begin n_fail++; $display("FAIL b2b_period%0d: got %0d required 6", i, read_cyc[i] - read_cyc[i-1]); end
      end
      n_checks++; if (rd_empty_err != 0) begin n_fail++; $display("FAIL b2b_read_empty: got %0d required 0", rd_empty_err); end
      $display("test_back_to_back: %0d reads", read_cyc.size());
   endtask

   task automatic test_random();
      int r0, s0, pushed;
`ifdef PIM_SEQ_STATS_EN
      r0 = int'(ops_retired);
      s0 = int'(stall_cycles);
`else
      r0 = 0; s0 = 0;
`endif
      clear_logs();
      rand_ready = 1;
      pushed = 0;
      for (int k = 0; k < 3000 && done_cyc.size() < 24; k++) begin
         if (pushed < 24 && $urandom_range(0, 2) == 0) begin
            push(mk(int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023))));
            pushed++;
         end
         run_cycle();
      end
      rand_ready = 0;
      wait_done(24, 10, "random");
      n_checks++; if (stream_errors() != 0) begin n_fail++; $display("FAIL rand_stream: %0d bad of %0d, required 0 of %0d", stream_errors(), hs_cmd.size(), exp_cmd.size()); end
      n_checks++; if (stab_err != 0) begin n_fail++; $display("FAIL rand_hold_stable: got %0d required 0", stab_err); end
      n_checks++; if (rd_empty_err != 0) begin n_fail++; $display("FAIL rand_read_empty: got %0d required 0", rd_empty_err); end
      n_checks++; if (read_cyc.size() != 24) begin n_fail++; $display("FAIL rand_reads: got %0d required 24", read_cyc.size()); end
`ifdef PIM_SEQ_STATS_EN
      n_checks++; if (int'(ops_retired) - r0 != nonnop_cnt) begin n_fail++; $display("FAIL rand_retired: got %0d required %0d", int'(ops_retired) - r0, nonnop_cnt); end
      n_checks++; if (int'(stall_cycles) - s0 != stall_obs) begin n_fail++; $display("FAIL rand_stalls: got %0d required %0d", int'(stall_cycles) - s0, stall_obs); end
`else
      if (r0 != 0 || s0 != 0) $display("test_random: unexpected start");
`endif
      $display("test_random: %0d entries, %0d commands, %0d stalls", done_cyc.size(), hs_cmd.size(), stall_obs);
   endtask

   task automatic test_reset_midway();
      int k = 0;
      clear_logs();
      push(mk(1, 300, 100, 200));
      while (hs_cmd.size() < 1 && k < 40) begin
         run_cycle();
         k++;
      end
      n_checks++; if (!(arr_valid === 1'b1 && arr_cmd === 2'd1)) begin n_fail++; $display("FAIL midrst_actb_pre: valid %0b cmd %0d required 1/1", arr_valid, arr_cmd); end
      reset = 1'b1;
      #1;
      n_checks++; if (arr_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %0b required 0", arr_valid); end
      n_checks++; if (busy !== 1'b0 || read !== 1'b0 || op_done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl: busy %0b read %0b done %0b required 0/0/0", busy, read, op_done); end
      n_checks++; if (arr_cmd !== 2'd0 || arr_row !== 10'd0) begin n_fail++; $display("FAIL midrst_cmdrow: got %0d/%0d required 0/0", arr_cmd, arr_row); end
`ifdef PIM_SEQ_STATS_EN
      n_checks++; if (ops_retired !== '0 || stall_cycles !== '0) begin n_fail++; $display("FAIL midrst_counters: got %0d/%0d required 0/0", ops_retired, stall_cycles); end
`endif
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      fifo_q.delete();
      fifo_empty = 1'b1;
      clear_logs();
      @(posedge clk); #1;
      push(mk(1, 12, 5, 9));
      wait_done(1, 40, "midrst_restart");
      n_checks++; if (stream_errors() != 0) begin n_fail++; $display("FAIL midrst_stream: %0d bad, required 0", stream_errors()); end
      if (read_cyc.size() >= 1 && hs_cyc.size() >= 1) begin
         n_checks++; if (hs_cyc[0] - read_cyc[0] != 2) begin n_fail++; $display("FAIL midrst_latency: got %0d required 2", hs_cyc[0] - read_cyc[0]); end
      end
      $display("test_reset_midway: restart with %0d commands", hs_cmd.size());
   endtask

   initial begin
      test_reset();
      test_logic_single();
      test_init_stall();
      test_nop_copy();
      test_back_to_back();
      test_random();
      test_reset_midway();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pim_row_sequencer.md
# pim_row_sequencer

Consumer stage for the address/op FIFOs of the memory-addressing stage. It pops one decoded entry at a time (dest/src1/src2 row addresses plus a 2-bit memory opcode) and expands it into a sequence of single-row commands on the crossbar-array port. Each command uses a valid/ready handshake. The block sits between the FIFO outputs and the PIM array controller, and is the only agent that asserts the FIFO read strobe.

## Interface
Parameters:
- ADDR_W, 10, row address width; matches the FIFO address outputs.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- fifo_empty  in  1  high when all upstream FIFOs are empty.
- dest_addr  in  ADDR_W  FIFO dest row; valid 1 cycle after read.
- src1_addr  in  ADDR_W  FIFO src1 row; valid 1 cycle after read.
- src2_addr  in  ADDR_W  FIFO src2 row; valid 1 cycle after read.
- mem_op  in  2  FIFO opcode; valid 1 cycle after read.
- read  out  1  single-cycle FIFO pop strobe.
- arr_valid  out  1  command valid toward the array.
- arr_ready  in  1  array accepts the command when arr_valid and arr_ready are both high.
- arr_cmd  out  2  command: 0 ACT_A, 1 ACT_B, 2 EVAL, 3 INIT.
- arr_row  out  ADDR_W  row address of the current command.
- busy  out  1  high in every state except IDLE.
- op_done  out  1  one-cycle pulse when an entry retires.
- ops_retired  out  CNT_W  retired (non-NOP) entry count; present only with the statistics macro.
- stall_cycles  out  CNT_W  cycles with arr_valid high and arr_ready low; present only with the statistics macro.

## Operation
- Opcodes:
  - 00 NOP: no commands issued.
  - 01 LOGIC: ACT_A(src1), ACT_B(src2), EVAL(dest).
  - 10 INIT: INIT(dest).
  - 11 COPY: ACT_A(src1), EVAL(dest).
- FSM states: IDLE, POP, LOAD, ISSUE, RETIRE.
- IDLE: when fifo_empty=0, assert read for exactly 1 cycle and go to POP.
- POP: wait state for FIFO read latency; go to LOAD.
- LOAD: register all three addresses and mem_op into local copies, clear step index, then:
  - NOP goes directly to RETIRE;
  - any other opcode goes to ISSUE.
- ISSUE: drive arr_valid=1 with arr_cmd/arr_row taken from the (opcode, step) table.
  - On handshake: increment step; on the last step of the opcode go to RETIRE.
  - arr_cmd/arr_row hold stable while arr_valid=1 and arr_ready=0.
- RETIRE: pulse op_done. Then:
  - if fifo_empty=0, assert read in this same cycle and go to POP (back-to-back);
  - otherwise go to IDLE.
- read is never asserted while fifo_empty=1, and never asserted outside IDLE/RETIRE.
- Captured addresses are used as-is; no arithmetic and no wrap (the upstream stage has already added offsets).

## Timing
- Reset values: read=0, arr_valid=0, arr_cmd=0, arr_row=0, busy=0, op_done=0, counters=0, state=IDLE.
- Reset asserted mid-sequence aborts immediately: arr_valid drops asynchronously and the partial entry is discarded.
- Latency with arr_ready tied high:
  - read to first arr_valid = 2 cycles;
  - LOGIC entry from read to op_done = 5 cycles.
- Back-to-back throughput with ready high: 1 entry per (steps+3) cycles; LOGIC = 6 cycles.
- fifo_empty is sampled only in IDLE and RETIRE; it is ignored in every other state.

## Configuration
- PIM_SEQ_STATS_EN defined:
  - ops_retired increments on each op_done of a non-NOP entry, saturating at all-ones;
  - stall_cycles increments every ISSUE cycle with arr_ready=0, also saturating.
- PIM_SEQ_STATS_EN undefined: both counter ports and their registers are absent; all other behaviour is identical.

## Structure
- Shared package pim_seq_pkg holds:
  - state enum;
  - arr_cmd enum (CMD_ACT_A/CMD_ACT_B/CMD_EVAL/CMD_INIT);
  - mem_op constants (OP_NOP/OP_LOGIC/OP_INIT/OP_COPY);
  - per-opcode step counts.
- One sub-module, pim_cmd_rom: combinational (opcode, step) → (cmd, row select, last).

## Test plan
- Single LOGIC entry {src1=5, src2=9, dest=12}, ready high → read at t0; commands ACT_A/5 at t2, ACT_B/9 at t3, EVAL/12 at t4; op_done at t5.
- INIT dest=1023 with ready held low 3 cycles → INIT/1023 held stable for 4 cycles; stall_cycles=3 (macro defined).
- NOP entry followed by COPY {src1=0, dest=7} → no arr_valid for the NOP; COPY issues ACT_A/0 then EVAL/7; ops_retired=1.
- Four queued LOGIC entries, ready high → read pulses exactly every 6 cycles; 4 op_done pulses; read never asserted while fifo_empty=1.
- Reset asserted during ACT_B of a LOGIC entry → arr_valid=0 at once, all outputs at reset values; on release, the next entry starts from IDLE with the 2-cycle latency.
